// File: rtl/park_space_allocator.sv
// Parking-space allocator: registered occupancy bitmap, request/ack entry FSM with
// lowest-index or round-robin space selection, and an FSM-independent exit path.
module park_space_allocator #(
  parameter int N_SPACES = 8,
  parameter int IDX_W    = $clog2(N_SPACES),
  parameter int POLICY   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enter_req,
  output logic                enter_ack,
  output logic                enter_reject,
  output logic [IDX_W-1:0]    enter_space,
  input  logic                exit_req,
  input  logic [IDX_W-1:0]    exit_space,
  output logic                exit_ack,
  output logic                exit_err,
  output logic [N_SPACES-1:0] occupancy,
  output logic [IDX_W:0]      free_count,
  output logic                full,
  output logic                empty
);

  typedef enum logic [1:0] {IDLE, SEARCH, GRANT, WAIT_DROP} state_t;

  localparam logic [IDX_W:0] N_COUNT = (IDX_W+1)'(N_SPACES);

  state_t               state_reg;
  logic [N_SPACES-1:0]  occupancy_reg;
  logic [IDX_W:0]       free_count_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     cand_reg;
  logic                 found_reg;
  logic [IDX_W-1:0]     enter_space_reg;
  logic                 enter_ack_reg;
  logic                 enter_reject_reg;
  logic                 exit_ack_reg;
  logic                 exit_err_reg;

  logic [IDX_W-1:0]     scan_base;
  logic [IDX_W-1:0]     scan_idx [N_SPACES];
  logic [N_SPACES-1:0]  scan_free;
  logic [IDX_W-1:0]     cand_next;
  logic                 found_next;

  logic                 exit_in_range;
  logic                 exit_hit;
  logic                 exit_ok;
  logic                 exit_bad;
  logic                 grant_ok;
  logic [N_SPACES-1:0]  exit_mask;
  logic [N_SPACES-1:0]  grant_mask;

  // Scan position gi maps to space (base + gi) mod N; base is 0 for lowest-index-first.
  assign scan_base = (POLICY == 1) ? rr_ptr_reg : '0;

  generate
    for (genvar gi = 0; gi < N_SPACES; gi++) begin : g_scan
      logic [IDX_W:0] scan_sum;
      assign scan_sum      = {1'b0, scan_base} + (IDX_W+1)'(gi);
      assign scan_idx[gi]  = (scan_sum >= N_COUNT) ? IDX_W'(scan_sum - N_COUNT)
                                                   : scan_sum[IDX_W-1:0];
      assign scan_free[gi] = ~occupancy_reg[scan_idx[gi]];
    end
  endgenerate

  // Descending loop so the earliest free scan position wins.
  always_comb begin
    found_next = 1'b0;
    cand_next  = '0;
    for (int i = N_SPACES - 1; i >= 0; i--) begin
      if (scan_free[i]) begin
        found_next = 1'b1;
        cand_next  = scan_idx[i];
      end
    end
  end

  assign exit_in_range = ({1'b0, exit_space} < N_COUNT);
  assign exit_hit      = exit_in_range ? occupancy_reg[exit_space] : 1'b0;
  assign exit_ok       = exit_req & exit_hit;
  assign exit_bad      = exit_req & ~exit_hit;
  assign grant_ok      = (state_reg == GRANT) && found_reg && !occupancy_reg[cand_reg];
  assign exit_mask     = exit_ok  ? (N_SPACES'(1) << exit_space) : '0;
  assign grant_mask    = grant_ok ? (N_SPACES'(1) << cand_reg)   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      occupancy_reg    <= '0;
      free_count_reg   <= N_COUNT;
      rr_ptr_reg       <= '0;
      cand_reg         <= '0;
      found_reg        <= 1'b0;
      enter_space_reg  <= '0;
      enter_ack_reg    <= 1'b0;
      enter_reject_reg <= 1'b0;
      exit_ack_reg     <= 1'b0;
      exit_err_reg     <= 1'b0;
    end else begin
      // Exit and grant always touch different bits, so both apply in one update.
      occupancy_reg    <= (occupancy_reg & ~exit_mask) | grant_mask;
      free_count_reg   <= free_count_reg + {IDX_W'(0), exit_ok} - {IDX_W'(0), grant_ok};
      exit_ack_reg     <= exit_ok;
      exit_err_reg     <= exit_bad;
      enter_ack_reg    <= 1'b0;
      enter_reject_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enter_req) state_reg <= SEARCH;
        end
        SEARCH: begin
          cand_reg  <= cand_next;
          found_reg <= found_next;
          state_reg <= GRANT;
        end
        GRANT: begin
          if (grant_ok) begin
            enter_ack_reg   <= 1'b1;
            enter_space_reg <= cand_reg;
            rr_ptr_reg      <= (cand_reg == IDX_W'(N_SPACES - 1)) ? '0 : cand_reg + 1'b1;
          end else begin
            enter_reject_reg <= 1'b1;
          end
          state_reg <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!enter_req) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign enter_ack    = enter_ack_reg;
  assign enter_reject = enter_reject_reg;
  assign enter_space  = enter_space_reg;
  assign exit_ack     = exit_ack_reg;
  assign exit_err     = exit_err_reg;
  assign occupancy    = occupancy_reg;
  assign free_count   = free_count_reg;
  assign full         = (free_count_reg == '0);
  assign empty        = (free_count_reg == N_COUNT);

endmodule

// File: tb/tb_park_space_allocator.sv
// Bench for park_space_allocator: one lowest-index instance (d=0) and one round-robin
// instance (d=1), directed scenarios then random traffic against an array-based model.
module tb_park_space_allocator;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       enter_req, enter_ack, enter_reject;
  logic [1:0]       exit_req, exit_ack, exit_err, full, empty;
  logic [1:0][2:0]  enter_space, exit_space;
  logic [1:0][7:0]  occupancy;
  logic [1:0][3:0]  free_count;

  int total = 0;
  int bad   = 0;

  bit m_occ [2][N];
  int m_ptr [2];

  park_space_allocator #(.N_SPACES(N), .POLICY(0)) u_lowest (
    .clk(clk), .rst(rst),
    .enter_req(enter_req[0]), .enter_ack(enter_ack[0]), .enter_reject(enter_reject[0]),
    .enter_space(enter_space[0]), .exit_req(exit_req[0]), .exit_space(exit_space[0]),
    .exit_ack(exit_ack[0]), .exit_err(exit_err[0]), .occupancy(occupancy[0]),
    .free_count(free_count[0]), .full(full[0]), .empty(empty[0])
  );

  park_space_allocator #(.N_SPACES(N), .POLICY(1)) u_rr (
    .clk(clk), .rst(rst),
    .enter_req(enter_req[1]), .enter_ack(enter_ack[1]), .enter_reject(enter_reject[1]),
    .enter_space(enter_space[1]), .exit_req(exit_req[1]), .exit_space(exit_space[1]),
    .exit_ack(exit_ack[1]), .exit_err(exit_err[1]), .occupancy(occupancy[1]),
    .free_count(free_count[1]), .full(full[1]), .empty(empty[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free(input int d);
    int c = 0;
    for (int k = 0; k < N; k++) if (!m_occ[d][k]) c++;
    return c;
  endfunction

  function automatic logic [7:0] m_map(input int d);
    logic [7:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = m_occ[d][k];
    return v;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      for (int k = 0; k < N; k++) m_occ[d][k] = 1'b0;
    end
  endtask

  task automatic chk_status(input int d);
    chk("occupancy",  occupancy[d],  m_map(d));
    chk("free_count", free_count[d], m_free(d));
    chk("full",       full[d],       m_free(d) == 0);
    chk("empty",      empty[d],      m_free(d) == N);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One car arrives; optionally an exit of ex_sp lands on the GRANT edge.
  task automatic car_enter(input int d, input int ex_sp, input int plan_sp);
    int  exp_sp = -1;
    int  idx;
    int  n = 0;
    bit  seen = 1'b0;
    bit  ex_ok;
    for (int k = 0; k < N; k++) begin
      idx = (d == 1) ? (m_ptr[d] + k) % N : k;
      if (exp_sp < 0 && !m_occ[d][idx]) exp_sp = idx;
    end
    ex_ok = (ex_sp >= 0) && m_occ[d][ex_sp];
    enter_req[d] = 1'b1;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (enter_ack[d] || enter_reject[d]) seen = 1'b1;
      else if (n == 2 && ex_sp >= 0) begin
        exit_req[d]   = 1'b1;
        exit_space[d] = 3'(ex_sp);
      end
    end
    exit_req[d] = 1'b0;
    chk("enter_latency", n, 3);
    chk("enter_ack",    enter_ack[d],    exp_sp >= 0);
    chk("enter_reject", enter_reject[d], exp_sp < 0);
    if (exp_sp >= 0) begin
      chk("enter_space", enter_space[d], exp_sp);
      m_occ[d][exp_sp] = 1'b1;
      m_ptr[d] = (exp_sp + 1) % N;
    end
    if (plan_sp >= 0) chk("plan_space", enter_space[d], plan_sp);
    if (ex_sp >= 0) begin
      chk("grant_exit_ack", exit_ack[d], ex_ok);
      chk("grant_exit_err", exit_err[d], !ex_ok);
      if (ex_ok) m_occ[d][ex_sp] = 1'b0;
    end
    chk_status(d);
    $display("enter d=%0d exit=%0d ack=%0b rej=%0b space=%0d occ=%02h",
             d, ex_sp, enter_ack[d], enter_reject[d], enter_space[d], occupancy[d]);
    enter_req[d] = 1'b0;
    tick();
    chk("enter_pulse_end", {enter_ack[d], enter_reject[d], exit_ack[d], exit_err[d]}, 0);
  endtask

  task automatic car_exit(input int d, input int sp);
    bit ok = m_occ[d][sp];
    exit_req[d]   = 1'b1;
    exit_space[d] = 3'(sp);
    tick();
    exit_req[d] = 1'b0;
    chk("exit_ack", exit_ack[d], ok);
    chk("exit_err", exit_err[d], !ok);
    if (ok) m_occ[d][sp] = 1'b0;
    chk_status(d);
    $display("exit  d=%0d space=%0d ack=%0b err=%0b occ=%02h",
             d, sp, exit_ack[d], exit_err[d], occupancy[d]);
    tick();
    chk("exit_pulse_end", {exit_ack[d], exit_err[d]}, 0);
  endtask

  initial begin
    int n;
    int r;
    bit seen;
    rst = 1'b1;
    enter_req = '0;
    exit_req = '0;
    exit_space = '0;
    model_clear();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk_status(d);
      chk("reset_pulses", {enter_ack[d], enter_reject[d], exit_ack[d], exit_err[d]}, 0);
      chk("reset_space", enter_space[d], 0);
    end
    rst = 1'b0;
    tick();

    // Lowest-index-first: fill, reject, release/reuse, double release.
    for (int i = 0; i < N; i++) car_enter(0, -1, i);
    chk("plan_full", full[0], 1'b1);
    car_enter(0, -1, -1);
    chk("plan_full_occ", occupancy[0], 8'hFF);
    car_exit(0, 3);
    chk("plan_occ_f7", occupancy[0], 8'hF7);
    car_enter(0, -1, 3);
    car_exit(0, 3);
    car_exit(0, 3);
    car_exit(0, 6);
    car_exit(0, 7);
    car_enter(0, -1, 3);
    chk("plan_occ_3f", occupancy[0], 8'h3F);
    car_enter(0, 5, 6);
    chk("plan_occ_5f", occupancy[0], 8'h5F);
    chk("plan_free_2", free_count[0], 2);

    // Round-robin: freed space 0 is skipped until the pointer wraps.
    for (int i = 0; i < 3; i++) car_enter(1, -1, i);
    car_exit(1, 0);
    for (int i = 3; i < N; i++) car_enter(1, -1, i);
    car_enter(1, -1, 0);
    car_enter(1, -1, -1);

    // Reset while the lowest-index instance is in SEARCH.
    enter_req[0] = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    model_clear();
    chk_status(0);
    chk_status(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_no_ack", {enter_ack[0], enter_reject[0]}, 0);
    end
    rst = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (enter_ack[0] || enter_reject[0]) seen = 1'b1;
    end
    chk("post_reset_latency", n, 3);
    chk("post_reset_ack", enter_ack[0], 1'b1);
    chk("post_reset_space", enter_space[0], 0);
    m_occ[0][0] = 1'b1;
    m_ptr[0] = 1;
    chk_status(0);
    $display("enter d=0 after reset ack=%0b space=%0d", enter_ack[0], enter_space[0]);
    enter_req[0] = 1'b0;
    tick();

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)      car_enter(d, -1, -1);
        else if (r < 5) car_enter(d, int'($urandom_range(0, N - 1)), -1);
        else            car_exit(d, int'($urandom_range(0, N - 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
